// File: rtl/minmax_reduce_nbit_pkg.sv
// Shared types and encodings for the streaming min/max reducer.
package minmax_reduce_nbit_pkg;

    // Reducer control states.
    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,   // awaiting element 0 of a vector
        ST_ACCUM = 2'd1,   // folding subsequent elements
        ST_DONE  = 2'd2    // holding the result for the sink
    } state_t;

    // Reduction mode encodings, as presented on the mode input.
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/minmax_reduce_nbit_cmp.sv
// Combinational WIDTH-bit greater-than comparator, signed or unsigned.
module cmp_nbit #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);

    // Strict a > b under the selected number interpretation.
    always_comb begin
        if (SIGNED) a_gt_b = ($signed(a) > $signed(b));
        else        a_gt_b = (a > b);
    end

endmodule

// File: rtl/minmax_reduce_nbit.sv
// Streaming min/max reducer: folds a valid/ready element stream into one
// result per vector (extreme value, its index, index-overflow flag).
module minmax_reduce_nbit
    import minmax_reduce_nbit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IDX_WIDTH = 16,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDX_WIDTH-1:0] out_index,
    output logic                 out_ovf
);

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [IDX_WIDTH-1:0] acc_idx;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 mode_q;
    logic                 ovf;
    logic                 valid_q;

    logic [WIDTH-1:0]     cmp_a;
    logic [WIDTH-1:0]     cmp_b;
    logic                 win;
    logic                 cnt_sat;

    // Steer comparator operands: max tests in_data > acc, min tests acc > in_data.
    always_comb begin
        if (mode_q == MODE_MIN) begin
            cmp_a = acc;
            cmp_b = in_data;
        end else begin
            cmp_a = in_data;
            cmp_b = acc;
        end
    end

    cmp_nbit #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (win)
    );

    assign cnt_sat = &cnt;

    // Reducer FSM with counter, accumulator and registered result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FIRST;
            acc     <= '0;
            acc_idx <= '0;
            cnt     <= '0;
            mode_q  <= MODE_MAX;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_FIRST: begin
                    if (in_valid) begin
                        acc     <= in_data;
                        acc_idx <= '0;
                        cnt     <= IDX_WIDTH'(1);
                        mode_q  <= mode;
                        ovf     <= 1'b0;
                        if (in_last) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        // Strict win only, so ties keep the earliest index;
                        // a saturated counter pins later winners to all-ones.
                        if (win) begin
                            acc     <= in_data;
                            acc_idx <= cnt;
                        end
                        if (cnt_sat) ovf <= 1'b1;
                        else         cnt <= cnt + IDX_WIDTH'(1);
                        if (in_last) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state   <= ST_FIRST;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_FIRST;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state != ST_DONE);
    assign out_valid = valid_q;
    assign out_data  = acc;
    assign out_index = acc_idx;
    assign out_ovf   = ovf;

endmodule
